// File: rtl/core_seq_pkg.sv
// core_seq_pkg: opcode and FSM encodings plus instruction field offsets.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package core_seq_pkg;

   typedef enum logic [2:0] {
      OP_LDI  = 3'd0,
      OP_ADD  = 3'd1,
      OP_SUB  = 3'd2,
      OP_AND  = 3'd3,
      OP_OUT  = 3'd4,
      OP_JMP  = 3'd5,
      OP_JC   = 3'd6,
      OP_HALT = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_EXEC  = 3'd3,
      S_OUTW  = 3'd4,
      S_HALT  = 3'd5
   } state_e;

   // Instruction layout, MSB first: op[2:0] | rd[RW-1:0] | imm[DW-1:0]
   function automatic int rd_lsb(input int dw);
      return dw;
   endfunction

   function automatic int op_lsb(input int dw, input int rw);
      return dw + rw;
   endfunction

   function automatic int inst_width(input int dw, input int rw);
      return 3 + rw + dw;
   endfunction

endpackage

// File: rtl/core_seq_alu.sv
// core_seq_alu: combinational ADD/SUB/AND on two DW-bit operands with carry/borrow.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: op (operation), a/b (operands), y (DW-bit result), cout (carry on ADD,
//        borrow on SUB, 0 on AND and all other ops).
module core_seq_alu
   import core_seq_pkg::*;
#(
   parameter int DW = 4
) (
   input  op_e           op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] y,
   output logic          cout
);

   logic [DW:0] wide;

   always_comb begin
      wide = '0;
      y    = '0;
      cout = 1'b0;
      case (op)
         OP_ADD: begin
            wide = {1'b0, a} + {1'b0, b};
            y    = wide[DW-1:0];
            cout = wide[DW];
         end
         OP_SUB: begin
            // Top bit of the zero-extended difference is set exactly when b > a.
            wide = {1'b0, a} - {1'b0, b};
            y    = wide[DW-1:0];
            cout = wide[DW];
         end
         OP_AND: begin
            y = a & b;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle accumulator core, FETCH/WAIT/EXEC sequencing over a valid-strobed imem port.
// Latency: >= 3 cycles per instruction (FETCH, WAIT >= 1, EXEC); OUT adds >= 1 OUTW cycle.
// Backpressure: OUTW holds out_valid/out_data and issues no fetch until out_ready.
// Ports: clk/reset (sync, active-high); imem_req/imem_addr/imem_valid/imem_inst fetch port;
//        out_valid/out_data/out_ready result port; carry flag; halted status.
module core_seq
   import core_seq_pkg::*;
#(
   parameter  int DW   = 4,
   parameter  int NREG = 4,
   parameter  int PCW  = 4,
   localparam int RW   = $clog2(NREG),
   localparam int IW   = inst_width(DW, RW)
) (
   input  logic           clk,
   input  logic           reset,
   output logic           imem_req,
   output logic [PCW-1:0] imem_addr,
   input  logic           imem_valid,
   input  logic [IW-1:0]  imem_inst,
   output logic           out_valid,
   output logic [DW-1:0]  out_data,
   input  logic           out_ready,
   output logic           carry,
   output logic           halted
);

   localparam int OP_LSB = op_lsb(DW, RW);
   localparam int RD_LSB = rd_lsb(DW);
   localparam int XW     = (PCW > DW) ? PCW : DW;

   state_e          state, state_nxt;
   logic [IW-1:0]   inst_q;
   logic [DW-1:0]   regs [NREG];
   logic [PCW-1:0]  pc;

   op_e             op;
   logic [RW-1:0]   rd;
   logic [DW-1:0]   imm;
   logic            rd_ok;
   logic [DW-1:0]   rd_val;
   logic [XW-1:0]   imm_x;
   logic [PCW-1:0]  jmp_tgt;
   logic [PCW-1:0]  pc_inc;
   logic [DW-1:0]   alu_y;
   logic            alu_c;

   assign op      = op_e'(inst_q[OP_LSB +: 3]);
   assign rd      = inst_q[RD_LSB +: RW];
   assign imm     = inst_q[DW-1:0];
   // NREG need not be a power of two; out-of-range rd writes are dropped, reads give 0.
   assign rd_ok   = ({1'b0, rd} < (RW+1)'(NREG));
   assign rd_val  = rd_ok ? regs[rd] : '0;
   // Zero-extend when PCW > DW, otherwise keep the low PCW bits of imm.
   assign imm_x   = XW'(imm);
   assign jmp_tgt = imm_x[PCW-1:0];
   assign pc_inc  = pc + PCW'(1);

   assign imem_addr = pc;

   core_seq_alu #(.DW(DW)) u_alu (
      .op   (op),
      .a    (regs[0]),
      .b    (regs[1]),
      .y    (alu_y),
      .cout (alu_c)
   );

   always_comb begin
      state_nxt = state;
      imem_req  = 1'b0;
      out_valid = 1'b0;
      halted    = 1'b0;
      case (state)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: begin
            imem_req  = 1'b1;
            state_nxt = S_WAIT;
         end
         S_WAIT:  if (imem_valid) state_nxt = S_EXEC;
         S_EXEC: begin
            case (op)
               OP_OUT:  state_nxt = S_OUTW;
               OP_HALT: state_nxt = S_HALT;
               default: state_nxt = S_FETCH;
            endcase
         end
         S_OUTW: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_FETCH;
         end
         S_HALT:  halted = 1'b1;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         pc       <= '0;
         carry    <= 1'b0;
         out_data <= '0;
         inst_q   <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         state <= state_nxt;
         // Strobes outside WAIT (including the FETCH cycle) are not captured.
         if (state == S_WAIT && imem_valid) inst_q <= imem_inst;
         if (state == S_EXEC) begin
            pc <= pc_inc;
            case (op)
               OP_LDI: if (rd_ok) regs[rd] <= imm;
               OP_ADD, OP_SUB, OP_AND: begin
                  if (rd_ok) regs[rd] <= alu_y;
                  carry <= alu_c;
               end
               OP_OUT: out_data <= rd_val;
               OP_JMP: pc <= jmp_tgt;
               OP_JC:  if (carry) pc <= jmp_tgt;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: directed plus randomized programs against an instruction-level reference model.
// Latency: memory model returns each fetch after a programmable number of cycles.
// Backpressure: out_ready driven always-high, random, or forced by the directed tests.
module tb_core_seq;
   localparam int DW = 4, NREG = 4, PCW = 4, IW = 9;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           imem_req;
   logic [PCW-1:0] imem_addr;
   logic           imem_valid;
   logic [IW-1:0]  imem_inst;
   logic           out_valid;
   logic [DW-1:0]  out_data;
   logic           out_ready;
   logic           carry;
   logic           halted;

   core_seq #(.DW(DW), .NREG(NREG), .PCW(PCW)) dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_valid (imem_valid),
      .imem_inst  (imem_inst),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .carry      (carry),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;
   logic [IW-1:0] mem [16];
   int  lat = 1;
   bit  spur = 1'b0;
   int  rdy_mode = 0;
   bit  rdy_force = 1'b1;
   int  cyc = 0, rst_cyc = 0;
   int  fetch_q[$], fetch_cyc_q[$], out_q[$], out_c_q[$];
   int  due_q[$], due_addr_q[$];
   int  exp_fetch[$], exp_out[$];
   int  exp_carry;
   bit  exp_halt;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [IW-1:0] enc(input int op, input int rd, input int imm);
      return IW'(op * 64 + rd * 16 + (imm % 16));
   endfunction

   task automatic clear_mem();
      for (int i = 0; i < 16; i++) mem[i] = enc(7, 0, 0);
   endtask

   // Environment: memory responder, out_ready driver and monitors, all on the negedge.
   initial begin
      imem_valid = 1'b0;
      imem_inst  = '0;
      out_ready  = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) rst_cyc = cyc;
         imem_valid = 1'b0;
         imem_inst  = '0;
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            imem_valid = 1'b1;
            imem_inst  = mem[due_addr_q[0]];
            void'(due_q.pop_front());
            void'(due_addr_q.pop_front());
         end
         if (imem_req) begin
            fetch_q.push_back(int'(imem_addr));
            fetch_cyc_q.push_back(cyc);
            due_q.push_back(cyc + lat);
            due_addr_q.push_back(int'(imem_addr));
            if (spur) begin
               imem_valid = 1'b1;
               imem_inst  = enc(7, 3, 15);
            end
         end
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = rdy_force;
         endcase
         if (out_valid && out_ready) begin
            out_q.push_back(int'(out_data));
            out_c_q.push_back(int'(carry));
         end
      end
   end

   task automatic do_reset(input int ncyc, input bit keep_mem);
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (ncyc) @(posedge clk);
      #1 reset = 1'b0;
      fetch_q.delete();
      fetch_cyc_q.delete();
      out_q.delete();
      out_c_q.delete();
      if (!keep_mem) begin
         due_q.delete();
         due_addr_q.delete();
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rst_imem_req"},  int'(imem_req),  0);
      check({tag, "_rst_out_valid"}, int'(out_valid), 0);
      check({tag, "_rst_out_data"},  int'(out_data),  0);
      check({tag, "_rst_carry"},     int'(carry),     0);
      check({tag, "_rst_halted"},    int'(halted),    0);
   endtask

   // Instruction-set reference: executes the program one instruction at a time.
   task automatic ref_run(input int max_steps);
      int pc, w, op, rd, imm, nxt, sum;
      int r[4];
      bit c;
      pc = 0;
      c  = 1'b0;
      foreach (r[i]) r[i] = 0;
      exp_fetch.delete();
      exp_out.delete();
      exp_halt = 1'b0;
      for (int s = 0; s < max_steps && !exp_halt; s++) begin
         exp_fetch.push_back(pc);
         w   = int'(mem[pc]);
         op  = w / 64;
         rd  = (w / 16) % 4;
         imm = w % 16;
         nxt = (pc + 1) % 16;
         case (op)
            0: r[rd] = imm;
            1: begin sum = r[0] + r[1]; c = (sum > 15); r[rd] = sum % 16; end
            2: begin c = (r[1] > r[0]); r[rd] = (r[0] - r[1] + 16) % 16; end
            3: begin r[rd] = r[0] & r[1]; c = 1'b0; end
            4: exp_out.push_back(r[rd]);
            5: nxt = imm;
            6: if (c) nxt = imm;
            default: exp_halt = 1'b1;
         endcase
         pc = nxt;
      end
      exp_carry = int'(c);
   endtask

   task automatic wait_run(input string tag, input int budget);
      int t = 0;
      while (!((exp_halt && halted && fetch_q.size() >= exp_fetch.size()) ||
               (!exp_halt && fetch_q.size() > exp_fetch.size())) && t < budget) begin
         @(negedge clk);
         #1;
         t++;
      end
      check({tag, "_in_time"}, int'(t < budget), 1);
   endtask

   task automatic compare_run(input string tag);
      check({tag, "_nfetch"}, fetch_q.size(), exp_fetch.size() + (exp_halt ? 0 : 1));
      for (int i = 0; i < exp_fetch.size(); i++)
         check($sformatf("%s_fetch%0d", tag, i), (i < fetch_q.size()) ? fetch_q[i] : -1, exp_fetch[i]);
      check({tag, "_nout"}, out_q.size(), exp_out.size());
      for (int i = 0; i < exp_out.size(); i++)
         check($sformatf("%s_out%0d", tag, i), (i < out_q.size()) ? out_q[i] : -1, exp_out[i]);
      if (exp_halt) begin
         check({tag, "_halted"}, int'(halted), 1);
         check({tag, "_carry"},  int'(carry),  exp_carry);
      end
   endtask

   task automatic wait_fetches(input int n, input int budget);
      int t = 0;
      while (fetch_q.size() < n && t < budget) begin
         @(negedge clk);
         #1;
         t++;
      end
      check($sformatf("fetch%0d_in_time", n), int'(t < budget), 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      int k, c_now, t;

      // ADD overflow sets carry, JC taken, OUT of the truncated sum.
      clear_mem();
      mem[0] = enc(0, 0, 9); mem[1] = enc(0, 1, 8); mem[2] = enc(1, 2, 0);
      mem[3] = enc(6, 0, 6); mem[6] = enc(4, 2, 0); mem[7] = enc(7, 0, 0);
      lat = 1; spur = 1'b0; rdy_mode = 0;
      do_reset(2, 1'b0);
      check_reset("t1");
      ref_run(50);
      wait_run("t1", 500);
      compare_run("t1");
      check("t1_first_req_delay", fetch_cyc_q.size() > 0 ? fetch_cyc_q[0] - rst_cyc : -1, 2);
      check("t1_out_value", out_q.size() > 0 ? out_q[0] : -1, 1);
      check("t1_jc_target", fetch_q.size() > 4 ? fetch_q[4] : -1, 6);
      check("t1_carry_at_out", out_c_q.size() > 0 ? out_c_q[0] : -1, 1);

      // SUB borrow, then AND clears carry.
      clear_mem();
      mem[0] = enc(0, 0, 3); mem[1] = enc(0, 1, 5); mem[2] = enc(2, 3, 0);
      mem[3] = enc(4, 3, 0); mem[4] = enc(3, 0, 0); mem[5] = enc(4, 0, 0);
      do_reset(2, 1'b0);
      ref_run(50);
      wait_run("t2", 500);
      compare_run("t2");
      check("t2_sub_out", out_q.size() > 0 ? out_q[0] : -1, 14);
      check("t2_sub_carry", out_c_q.size() > 0 ? out_c_q[0] : -1, 1);
      check("t2_and_out", out_q.size() > 1 ? out_q[1] : -1, 1);
      check("t2_and_carry", int'(carry), 0);

      // Backpressure: hold OUT for 5 cycles, then release.
      clear_mem();
      mem[0] = enc(0, 0, 5); mem[1] = enc(4, 0, 0); mem[2] = enc(0, 1, 2); mem[3] = enc(4, 1, 0);
      rdy_mode = 2; rdy_force = 1'b0;
      do_reset(2, 1'b0);
      ref_run(50);
      t = 0;
      while (!out_valid && t < 100) begin @(negedge clk); #1; t++; end
      check("t3_out_valid_rise", int'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("t3_hold_valid%0d", i), int'(out_valid), 1);
         check($sformatf("t3_hold_data%0d", i),  int'(out_data),  5);
         check($sformatf("t3_hold_noreq%0d", i), int'(imem_req),  0);
         @(negedge clk);
         #1;
      end
      k = fetch_q.size();
      c_now = cyc;
      rdy_force = 1'b1;
      wait_fetches(k + 1, 50);
      check("t3_refetch_cycle", fetch_cyc_q.size() > k ? fetch_cyc_q[k] - c_now : -1, 2);
      wait_run("t3", 500);
      compare_run("t3");
      rdy_mode = 0;

      // Latency 4 with a spurious strobe in every FETCH cycle.
      clear_mem();
      mem[0] = enc(0, 0, 2); mem[1] = enc(0, 1, 3); mem[2] = enc(1, 2, 0); mem[3] = enc(4, 2, 0);
      lat = 4; spur = 1'b1;
      do_reset(2, 1'b0);
      ref_run(50);
      wait_run("t4", 1000);
      compare_run("t4");
      for (int i = 0; i < 3; i++)
         check($sformatf("t4_period%0d", i),
               fetch_cyc_q.size() > i + 1 ? fetch_cyc_q[i+1] - fetch_cyc_q[i] : -1, 6);
      lat = 1; spur = 1'b0;

      // JMP 15 then pc wraps to 0; carry steers the second visit of address 0.
      clear_mem();
      mem[0] = enc(6, 0, 5); mem[1] = enc(0, 0, 15); mem[2] = enc(0, 1, 1); mem[3] = enc(1, 2, 0);
      mem[4] = enc(5, 0, 15); mem[5] = enc(4, 0, 0); mem[6] = enc(7, 0, 0); mem[15] = enc(0, 0, 7);
      do_reset(2, 1'b0);
      ref_run(50);
      wait_run("t5", 500);
      compare_run("t5");
      check("t5_jmp_addr", fetch_q.size() > 5 ? fetch_q[5] : -1, 15);
      check("t5_wrap_addr", fetch_q.size() > 6 ? fetch_q[6] : -1, 0);
      check("t5_r0_out", out_q.size() > 0 ? out_q[0] : -1, 7);

      // Halted core stays silent.
      k = fetch_q.size();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("t6_halted%0d", i), int'(halted), 1);
      end
      check("t6_no_req", fetch_q.size(), k);

      // Reset in the middle of WAIT; the late return lands in IDLE and is dropped.
      clear_mem();
      mem[0] = enc(0, 0, 15); mem[1] = enc(0, 1, 1); mem[2] = enc(1, 2, 0); mem[3] = enc(0, 3, 9);
      mem[4] = enc(4, 3, 0); mem[5] = enc(0, 0, 4); mem[6] = enc(4, 0, 0); mem[7] = enc(7, 0, 0);
      lat = 4;
      do_reset(2, 1'b0);
      wait_fetches(6, 200);
      repeat (2) @(posedge clk);
      do_reset(1, 1'b1);
      check_reset("t7");
      ref_run(50);
      wait_run("t7", 1000);
      compare_run("t7");
      check("t7_first_req_delay", fetch_cyc_q.size() > 0 ? fetch_cyc_q[0] - rst_cyc : -1, 2);

      // Random programs, random latency, random backpressure.
      for (int it = 0; it < 12; it++) begin
         for (int i = 0; i < 16; i++)
            mem[i] = enc($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 15));
         lat      = $urandom_range(1, 3);
         spur     = 1'($urandom_range(0, 1));
         rdy_mode = 1;
         do_reset(2, 1'b0);
         ref_run(30);
         wait_run($sformatf("rnd%0d", it), 3000);
         compare_run($sformatf("rnd%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
